// File: rtl/ifetch_stage.sv
// Instruction-fetch stage and IF/ID register. It owns the PC and drives the 1-cycle SRAM.
// A one-entry hold buffer keeps the SRAM response that arrives while IF/ID is stalled.
module ifetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] target_pc_i,
  output logic        im_cs_o,
  output logic [31:0] im_addr_o,
  input  logic [31:0] im_rdata_i,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_inst_o,
  output logic        if_id_valid_o
);

  typedef enum logic {RUN, HOLD} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] resp_pc_reg, resp_pc_next;
  logic        resp_valid_reg, resp_valid_next;
  logic [31:0] hold_inst_reg, hold_inst_next;
  logic [31:0] if_id_pc_reg, if_id_pc_next;
  logic [31:0] if_id_inst_reg, if_id_inst_next;
  logic        if_id_valid_reg, if_id_valid_next;
  logic [31:0] inst_src;

  // A redirect issues its target immediately, so the bubble costs only one cycle.
  assign im_addr_o = flush_i ? target_pc_i : pc_reg;
  assign im_cs_o   = rst_n & (flush_i | ~stall_i);

  // Once stalled, the live SRAM output no longer belongs to the pending address.
  assign inst_src = (state_reg == HOLD) ? hold_inst_reg : im_rdata_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= RUN;
      pc_reg          <= RESET_PC;
      resp_pc_reg     <= 32'h0;
      resp_valid_reg  <= 1'b0;
      hold_inst_reg   <= 32'h0;
      if_id_pc_reg    <= 32'h0;
      if_id_inst_reg  <= NOP_INST;
      if_id_valid_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      resp_pc_reg     <= resp_pc_next;
      resp_valid_reg  <= resp_valid_next;
      hold_inst_reg   <= hold_inst_next;
      if_id_pc_reg    <= if_id_pc_next;
      if_id_inst_reg  <= if_id_inst_next;
      if_id_valid_reg <= if_id_valid_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    resp_pc_next     = resp_pc_reg;
    resp_valid_next  = resp_valid_reg;
    hold_inst_next   = hold_inst_reg;
    if_id_pc_next    = if_id_pc_reg;
    if_id_inst_next  = if_id_inst_reg;
    if_id_valid_next = if_id_valid_reg;

    if (flush_i) begin
      // The in-flight response is simply never consumed.
      if_id_pc_next    = 32'h0;
      if_id_inst_next  = NOP_INST;
      if_id_valid_next = 1'b0;
      pc_next          = target_pc_i + 32'd4;
      resp_pc_next     = target_pc_i;
      resp_valid_next  = 1'b1;
      state_next       = RUN;
    end else if (stall_i) begin
      if (state_reg == RUN) begin
        hold_inst_next = im_rdata_i;
        state_next     = HOLD;
      end
    end else begin
      if_id_pc_next    = resp_pc_reg;
      if_id_inst_next  = resp_valid_reg ? inst_src : NOP_INST;
      if_id_valid_next = resp_valid_reg;
      pc_next          = pc_reg + 32'd4;
      resp_pc_next     = pc_reg;
      resp_valid_next  = 1'b1;
      state_next       = RUN;
    end
  end

  assign if_id_pc_o    = if_id_pc_reg;
  assign if_id_inst_o  = if_id_inst_reg;
  assign if_id_valid_o = if_id_valid_reg;

endmodule

// File: tb/tb_ifetch_stage.sv
// Bench for ifetch_stage: directed vector table, hand sequences for reset/wrap corners,
// and random stall/flush traffic checked against an in-order fetch-stream model.
`timescale 1ns/1ps
module tb_ifetch_stage;
  localparam logic [31:0] K   = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, stall, flush, corrupt;
  logic [31:0] target;

  logic        cs_a, valid_a, cs_b, valid_b;
  logic [31:0] addr_a, rdata_q_a, rdata_a, pc_a, inst_a;
  logic [31:0] addr_b, rdata_q_b, rdata_b, pc_b, inst_b;

  ifetch_stage dut_a (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .flush_i(flush), .target_pc_i(target),
    .im_cs_o(cs_a), .im_addr_o(addr_a), .im_rdata_i(rdata_a),
    .if_id_pc_o(pc_a), .if_id_inst_o(inst_a), .if_id_valid_o(valid_a)
  );

  ifetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_b (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .flush_i(flush), .target_pc_i(target),
    .im_cs_o(cs_b), .im_addr_o(addr_b), .im_rdata_i(rdata_b),
    .if_id_pc_o(pc_b), .if_id_inst_o(inst_b), .if_id_valid_o(valid_b)
  );

  // SRAM models: one-cycle read latency, data derived from the address.
  initial begin
    rdata_q_a = 32'h0;
    rdata_q_b = 32'h0;
  end
  always @(posedge clk) begin
    if (cs_a) rdata_q_a <= addr_a ^ K;
    if (cs_b) rdata_q_b <= addr_b ^ K;
  end
  assign rdata_a = corrupt ? 32'hDEAD_BEEF : rdata_q_a;
  assign rdata_b = corrupt ? 32'hDEAD_BEEF : rdata_q_b;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        stall;
    logic        flush;
    logic [31:0] tgt;
    logic        corr;
    logic        exp_cs;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
  } vec_t;

  vec_t vt[16];

  task automatic do_reset();
    rst_n   = 1'b0;
    stall   = 1'b0;
    flush   = 1'b0;
    target  = 32'h0;
    corrupt = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_cs",    {31'h0, cs_a},    32'h0);
    chk("rst_valid", {31'h0, valid_a}, 32'h0);
    chk("rst_pc",    pc_a,             32'h0);
    chk("rst_inst",  inst_a,           NOP);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drive one cycle at the negedge, check the combinational fetch outputs, then IF/ID after the edge.
  task automatic cycle_a(input string tag, input logic s, input logic f, input logic [31:0] t,
                         input logic c, input logic e_cs, input logic [31:0] e_addr,
                         input logic e_valid, input logic [31:0] e_pc, input logic [31:0] e_inst);
    stall = s; flush = f; target = t; corrupt = c;
    #1;
    chk({tag, "_cs"},   {31'h0, cs_a}, {31'h0, e_cs});
    chk({tag, "_addr"}, addr_a,        e_addr);
    @(negedge clk);
    chk({tag, "_valid"}, {31'h0, valid_a}, {31'h0, e_valid});
    chk({tag, "_pc"},    pc_a,             e_pc);
    chk({tag, "_inst"},  inst_a,           e_inst);
    $display("%s: stall=%0b flush=%0b cs=%0b addr=%h -> valid=%0b pc=%h inst=%h",
             tag, s, f, cs_a, addr_a, valid_a, pc_a, inst_a);
  endtask

  // Reference: a queue of issued-but-unconsumed addresses and the next sequential PC.
  logic [31:0] m_pc, m_ipc, m_inst;
  logic        m_valid, prev_hold;
  logic [31:0] q[$];

  initial begin
    vt[0]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h000, 1'b0, 32'h000, NOP};
    vt[1]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h004, 1'b1, 32'h000, K ^ 32'h000};
    vt[2]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h008, 1'b1, 32'h004, K ^ 32'h004};
    vt[3]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h00C, 1'b1, 32'h008, K ^ 32'h008};
    vt[4]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h010, 1'b1, 32'h008, K ^ 32'h008};
    vt[5]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h010, 1'b1, 32'h008, K ^ 32'h008};
    vt[6]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h010, 1'b1, 32'h008, K ^ 32'h008};
    vt[7]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h010, 1'b1, 32'h00C, K ^ 32'h00C};
    vt[8]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h014, 1'b1, 32'h010, K ^ 32'h010};
    vt[9]  = '{1'b0, 1'b1, 32'h100, 1'b0, 1'b1, 32'h100, 1'b0, 32'h000, NOP};
    vt[10] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h104, 1'b1, 32'h100, K ^ 32'h100};
    vt[11] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h108, 1'b1, 32'h104, K ^ 32'h104};
    vt[12] = '{1'b1, 1'b1, 32'h200, 1'b0, 1'b1, 32'h200, 1'b0, 32'h000, NOP};
    vt[13] = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h204, 1'b0, 32'h000, NOP};
    vt[14] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h204, 1'b1, 32'h200, K ^ 32'h200};
    vt[15] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h208, 1'b1, 32'h204, K ^ 32'h204};

    // Directed table: sequential fetch, 3-cycle stall with corrupted SRAM, flush, flush+stall.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      cycle_a($sformatf("vec%0d", i), vt[i].stall, vt[i].flush, vt[i].tgt, vt[i].corr,
              vt[i].exp_cs, vt[i].exp_addr, vt[i].exp_valid, vt[i].exp_pc, vt[i].exp_inst);
    end

    // Stall in the first cycle after reset release.
    do_reset();
    cycle_a("pst0", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h000, 1'b0, 32'h000, NOP);
    cycle_a("pst1", 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h000, 1'b0, 32'h000, NOP);
    cycle_a("pst2", 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h000, 1'b0, 32'h000, NOP);
    cycle_a("pst3", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h004, 1'b1, 32'h000, K);

    // PC wrap on the instance reset to FFFF_FFF8.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("wrap_addr%0d", i), addr_b, 32'hFFFF_FFF8 + 32'(i) * 32'd4);
      @(negedge clk);
      $display("wrap%0d: valid=%0b pc=%h inst=%h", i, valid_b, pc_b, inst_b);
    end
    chk("wrap_valid", {31'h0, valid_b}, 32'h1);
    chk("wrap_pc",    pc_b,             32'h0000_0000);
    chk("wrap_inst",  inst_b,           K);

    // Asynchronous reset while in HOLD with a valid instruction in IF/ID.
    do_reset();
    cycle_a("mh0", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h000, 1'b0, 32'h000, NOP);
    cycle_a("mh1", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h004, 1'b1, 32'h000, K);
    cycle_a("mh2", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h008, 1'b1, 32'h000, K);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mh_rst_valid", {31'h0, valid_a}, 32'h0);
    chk("mh_rst_pc",    pc_a,             32'h0);
    chk("mh_rst_inst",  inst_a,           NOP);
    chk("mh_rst_cs",    {31'h0, cs_a},    32'h0);
    chk("mh_rst_addr",  addr_a,           32'h0);
    @(negedge clk);
    stall = 1'b0;
    rst_n = 1'b1;
    cycle_a("mh3", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h000, 1'b0, 32'h000, NOP);
    cycle_a("mh4", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h004, 1'b1, 32'h000, K);

    // Random stall/flush traffic against the fetch-stream model.
    do_reset();
    m_pc = 32'h0; m_ipc = 32'h0; m_inst = NOP; m_valid = 1'b0; prev_hold = 1'b0;
    q.delete();
    for (int i = 0; i < 400; i++) begin
      stall   = ($urandom % 100) < 30;
      flush   = ($urandom % 100) < 10;
      target  = $urandom;
      corrupt = prev_hold;
      #1;
      chk("rnd_cs",   {31'h0, cs_a}, {31'h0, flush | ~stall});
      chk("rnd_addr", addr_a,        flush ? target : m_pc);
      if (flush) begin
        m_ipc = 32'h0; m_inst = NOP; m_valid = 1'b0;
        q.delete();
        q.push_back(target);
        m_pc = target + 32'd4;
      end else if (!stall) begin
        if (q.size() > 0) begin
          m_ipc = q[0]; m_inst = q[0] ^ K; m_valid = 1'b1;
        end else begin
          m_ipc = 32'h0; m_inst = NOP; m_valid = 1'b0;
        end
        q.delete();
        q.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
      prev_hold = stall & ~flush;
      @(negedge clk);
      chk("rnd_valid", {31'h0, valid_a}, {31'h0, m_valid});
      chk("rnd_pc",    pc_a,             m_ipc);
      chk("rnd_inst",  inst_a,           m_inst);
      $display("rnd%0d: stall=%0b flush=%0b -> valid=%0b pc=%h inst=%h",
               i, stall, flush, valid_a, pc_a, inst_a);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
